// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and widths for the uart_tx arbiter slice
package uart_tx_arbiter_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO
    } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte streams plus uart_tx side signals of the arbiter
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ*UART_BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_last;
    logic [N_REQ-1:0]             req_ready;
    logic [UART_BYTE_W-1:0]       tx_data;
    logic                         tx_send;
    logic                         tx_busy;
    logic [N_REQ-1:0]             grant;
    logic                         tx_err;

    modport slave (
        input  req_data, req_valid, req_last, tx_busy,
        output req_ready, tx_data, tx_send, grant, tx_err
    );

    modport master (
        output req_data, req_valid, req_last, tx_busy,
        input  req_ready, tx_data, tx_send, grant, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rtl/uart_tx_arbiter_rr_arbiter.sv - combinational round-robin pick, search starts at ptr+1
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // k=N wraps back to ptr itself, so the last owner is considered last
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx between N_REQ byte streams
// Optional UART_ARB_LOCK_EN keeps a channel owning the uart until it sends a req_last byte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int BUSY_WAIT_MAX = 8
) (
    input logic             clk,
    input logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(BUSY_WAIT_MAX + 1);

    uart_arb_state_t        state, state_nxt;
    logic [IW-1:0]          ptr;
    logic [N_REQ-1:0]       grant_q;
    logic [N_REQ-1:0]       elig;
    logic [N_REQ-1:0]       win_gnt;
    logic [IW-1:0]          win_idx;
    logic [UART_BYTE_W-1:0] win_data;
    logic [UART_BYTE_W-1:0] data_q;
    logic [CW-1:0]          cnt;
    logic                   err_q;
    logic                   accept;
    logic                   timeout;

`ifdef UART_ARB_LOCK_EN
    logic lock;
    // grant_q still names the last winner, which is the only channel allowed while locked
    assign elig = lock ? (bus.req_valid & grant_q) : bus.req_valid;
`else
    assign elig = bus.req_valid;
`endif

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (elig),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) win_data = bus.req_data[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    assign timeout = (state == WAIT_HI) && !bus.tx_busy && (cnt == CW'(BUSY_WAIT_MAX - 1));

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.req_ready = '0;
        bus.tx_send   = 1'b0;
        case (state)
            IDLE: begin
                // tx_busy gate keeps us off a frame still running from before a reset
                if (!rst && !bus.tx_busy && |win_gnt) begin
                    accept        = 1'b1;
                    bus.req_ready = win_gnt;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                bus.tx_send = 1'b1;
                state_nxt   = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy)  state_nxt = WAIT_LO;
                else if (timeout) state_nxt = IDLE;
            end
            WAIT_LO: begin
                if (!bus.tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= IW'(N_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_q  <= win_data;
                grant_q <= win_gnt;
                ptr     <= win_idx;
`ifdef UART_ARB_LOCK_EN
                lock    <= !bus.req_last[win_idx];
`endif
            end
            // cnt holds clocks elapsed since the tx_send cycle
            if (state == SEND)                         cnt <= CW'(1);
            else if (state == WAIT_HI && !bus.tx_busy) cnt <= cnt + 1'b1;
            else                                       cnt <= '0;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.tx_data = data_q;
    assign bus.grant   = grant_q;
    assign bus.tx_err  = err_q;
endmodule
